uart_text_ctrl: RTL and testbench

//  Cursor/scroll controller between the UART receiver and the character tile RAM of the VGA text terminal.
//  - Consumes received ASCII bytes and sequences writes into the 80x30 text buffer.
//  - Handles printable chars, CR, LF and BS, plus end-of-line wrap.
//  - Scrolls in hardware by rotating a row offset and clearing the new bottom row.
//  - The pixel-side text generator adds scroll_y to its tile row (mod ROWS) when reading the RAM.

---
 rtl/uart_term_pkg.sv | 27 ++
 rtl/uart_text_ctrl.sv | 174 +++++++++++++++++
 tb/tb_uart_text_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_term_pkg.sv
// rtl/uart_term_pkg.sv - shared constants, state encoding and address packing for the UART text terminal
package uart_term_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;

  localparam logic [7:0] ASC_CR        = 8'h0D;
  localparam logic [7:0] ASC_LF        = 8'h0A;
  localparam logic [7:0] ASC_BS        = 8'h08;
  localparam logic [7:0] ASC_SPACE     = 8'h20;
  localparam logic [7:0] ASC_PRINT_MIN = 8'h20;
  localparam logic [7:0] ASC_PRINT_MAX = 8'h7E;

  localparam logic [6:0] BLANK_DEF = 7'h20;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } term_state_e;

  // Tile RAM address as seen by both the writer and the pixel-side reader.
  function automatic logic [11:0] pack_addr(input logic [4:0] row, input logic [6:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/uart_text_ctrl.sv
// rtl/uart_text_ctrl.sv - cursor/scroll controller turning received UART bytes into text tile RAM writes
module uart_text_ctrl
  import uart_term_pkg::*;
#(
  parameter int         COLS  = COLS_DEF,
  parameter int         ROWS  = ROWS_DEF,
  parameter logic [6:0] BLANK = BLANK_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_done_tick,
  input  logic [7:0]  rx_data,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [6:0]  wr_data,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic [4:0]  scroll_y,
  output logic        busy,
  output logic        drop_tick
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [7:0] CNT_DONE = 8'(COLS);
  localparam logic [5:0] ROWS6    = 6'(ROWS);

  term_state_e state_q, state_d;
  logic [4:0]  cnt_row_q, cnt_row_d;
  logic [7:0]  cnt_col_q, cnt_col_d;
  logic [6:0]  cur_x_q, cur_x_d;
  logic [4:0]  cur_y_q, cur_y_d;
  logic [4:0]  scroll_y_q, scroll_y_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [6:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        drop_tick_q, drop_tick_d;

  logic [5:0]  row_sum;
  logic [4:0]  phys_row;
  logic        do_nl;
  logic        is_print;

  always_comb begin
    row_sum  = {1'b0, cur_y_q} + {1'b0, scroll_y_q};
    phys_row = (row_sum >= ROWS6) ? 5'(row_sum - ROWS6) : row_sum[4:0];
    is_print = (rx_data >= ASC_PRINT_MIN) && (rx_data <= ASC_PRINT_MAX);
  end

  always_comb begin
    state_d     = state_q;
    cnt_row_d   = cnt_row_q;
    cnt_col_d   = cnt_col_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    scroll_y_d  = scroll_y_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    drop_tick_d = 1'b0;
    do_nl       = 1'b0;

    case (state_q)
      // INIT sweeps every row; CLEAR reuses the same counters for one row.
      // cnt_col == COLS marks the trailing cycle before busy drops.
      ST_INIT, ST_CLEAR: begin
        drop_tick_d = rx_done_tick;
        if (cnt_col_q == CNT_DONE) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = pack_addr(cnt_row_q, cnt_col_q[6:0]);
          wr_data_d = BLANK;
          if (cnt_col_q[6:0] == LAST_COL) begin
            if ((state_q == ST_INIT) && (cnt_row_q != LAST_ROW)) begin
              cnt_row_d = cnt_row_q + 5'd1;
              cnt_col_d = 8'd0;
            end else begin
              cnt_col_d = CNT_DONE;
            end
          end else begin
            cnt_col_d = cnt_col_q + 8'd1;
          end
        end
      end

      ST_IDLE: begin
        if (rx_done_tick) begin
          if (is_print) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pack_addr(phys_row, cur_x_q);
            wr_data_d = rx_data[6:0];
            if (cur_x_q == LAST_COL) begin
              cur_x_d = 7'd0;
              do_nl   = 1'b1;
            end else begin
              cur_x_d = cur_x_q + 7'd1;
            end
          end else if (rx_data == ASC_CR) begin
            cur_x_d = 7'd0;
          end else if (rx_data == ASC_LF) begin
            do_nl = 1'b1;
          end else if ((rx_data == ASC_BS) && (cur_x_q != 7'd0)) begin
            cur_x_d   = cur_x_q - 7'd1;
            wr_en_d   = 1'b1;
            wr_addr_d = pack_addr(phys_row, cur_x_q - 7'd1);
            wr_data_d = BLANK;
          end
        end
      end

      default: begin
        state_d   = ST_INIT;
        busy_d    = 1'b1;
        cnt_row_d = 5'd0;
        cnt_col_d = 8'd0;
      end
    endcase

    // At the bottom row the old top physical row becomes the new bottom row.
    if (do_nl) begin
      if (cur_y_q != LAST_ROW) begin
        cur_y_d = cur_y_q + 5'd1;
      end else begin
        scroll_y_d = (scroll_y_q == LAST_ROW) ? 5'd0 : scroll_y_q + 5'd1;
        state_d    = ST_CLEAR;
        busy_d     = 1'b1;
        cnt_row_d  = scroll_y_q;
        cnt_col_d  = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_row_q   <= 5'd0;
      cnt_col_q   <= 8'd0;
      cur_x_q     <= 7'd0;
      cur_y_q     <= 5'd0;
      scroll_y_q  <= 5'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 12'd0;
      wr_data_q   <= BLANK;
      busy_q      <= 1'b1;
      drop_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_row_q   <= cnt_row_d;
      cnt_col_q   <= cnt_col_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      scroll_y_q  <= scroll_y_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      drop_tick_q <= drop_tick_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign scroll_y  = scroll_y_q;
  assign busy      = busy_q;
  assign drop_tick = drop_tick_q;

endmodule

// File: tb/tb_uart_text_ctrl.sv
// tb/tb_uart_text_ctrl.sv - self-checking bench for uart_text_ctrl against a queue-based terminal model
module tb_uart_text_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_done_tick = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic [4:0]  scroll_y;
  logic        busy;
  logic        drop_tick;

  uart_text_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cur_x        (cur_x),
    .cur_y        (cur_y),
    .scroll_y     (scroll_y),
    .busy         (busy),
    .drop_tick    (drop_tick)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Terminal model: cursor, scroll offset, pending write queue and busy countdown.
  int mx, my, msy, busy_cnt;
  int wq[$];
  logic        exp_wr_en, exp_drop, exp_busy, exp_addr_valid;
  logic [11:0] exp_addr;
  logic [6:0]  exp_data;

  function automatic int enc(input int row, input int col, input int data);
    return ((row * 128 + col) << 7) | data;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; msy = 0;
    wq.delete();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        wq.push_back(enc(r, c, 32));
    busy_cnt = ROWS * COLS + 1;
    exp_wr_en = 1'b0; exp_drop = 1'b0; exp_busy = 1'b1;
    exp_addr = 12'd0; exp_data = 7'h20; exp_addr_valid = 1'b1;
  endtask

  task automatic model_write(input int row, input int col, input int data);
    exp_wr_en = 1'b1; exp_addr_valid = 1'b1;
    exp_addr = 12'(row * 128 + col);
    exp_data = 7'(data);
  endtask

  task automatic model_newline();
    int bottom;
    if (my < ROWS - 1) begin
      my++;
    end else begin
      msy = (msy + 1) % ROWS;
      bottom = (my + msy) % ROWS;
      for (int c = 0; c < COLS; c++) wq.push_back(enc(bottom, c, 32));
      busy_cnt = COLS + 1;
    end
  endtask

  task automatic model_step(input logic tick, input logic [7:0] b);
    int row, w;
    exp_wr_en = 1'b0; exp_drop = 1'b0; exp_addr_valid = 1'b0;
    if (busy_cnt > 0) begin
      exp_drop = tick;
      if (wq.size() > 0) begin
        w = wq.pop_front();
        exp_wr_en = 1'b1; exp_addr_valid = 1'b1;
        exp_addr = 12'(w >> 7);
        exp_data = 7'(w & 127);
      end
      busy_cnt--;
    end else if (tick) begin
      row = (my + msy) % ROWS;
      if (b >= 8'h20 && b <= 8'h7E) begin
        model_write(row, mx, int'(b));
        if (mx == COLS - 1) begin
          mx = 0;
          model_newline();
        end else begin
          mx++;
        end
      end else if (b == 8'h0D) begin
        mx = 0;
      end else if (b == 8'h0A) begin
        model_newline();
      end else if (b == 8'h08 && mx > 0) begin
        mx--;
        model_write(row, mx, 32);
      end
    end
    exp_busy = (busy_cnt > 0);
  endtask

  initial begin
    logic       s_tick, s_rst;
    logic [7:0] s_data;
    forever begin
      @(posedge clk);
      s_tick = rx_done_tick; s_data = rx_data; s_rst = rst_n;
      #1;
      if (!s_rst) model_reset();
      else model_step(s_tick, s_data);
      check("wr_en", wr_en, exp_wr_en);
      if (exp_addr_valid) begin
        check("wr_addr", wr_addr, exp_addr);
        check("wr_data", wr_data, exp_data);
      end
      check("cur_x", cur_x, mx);
      check("cur_y", cur_y, my);
      check("scroll_y", scroll_y, msy);
      check("busy", busy, exp_busy);
      check("drop_tick", drop_tick, exp_drop);
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && busy; i++) @(negedge clk);
    check("wait_idle_timeout", busy, 0);
  endtask

  task automatic run_init(input string tag);
    int n, bad, cyc;
    logic [11:0] lst;
    n = 0; bad = 0; cyc = 0; lst = 12'd0;
    do begin
      @(negedge clk);
      cyc++;
      if (wr_en) begin
        n++;
        lst = wr_addr;
        if (wr_data != 7'h20) bad++;
      end
    end while (busy && cyc < 3000);
    check({tag, "_writes"}, n, 2400);
    check({tag, "_last_addr"}, lst, 12'hECF);
    check({tag, "_bad_data"}, bad, 0);
    check({tag, "_busy_done"}, busy, 0);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55) return 8'($urandom_range(32, 126));
    if (r < 65) return 8'h0A;
    if (r < 72) return 8'h0D;
    if (r < 85) return 8'h08;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int n, drops, bad;
    #(40 * 60000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, drops, bad;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 7'h20);
    check("rst_busy", busy, 1);
    check("rst_drop", drop_tick, 0);
    rst_n = 1'b1;
    run_init("init");

    send(8'h41);
    check("A_wr_en", wr_en, 1);
    check("A_addr", wr_addr, 12'h000);
    check("A_data", wr_data, 7'h41);
    check("A_cur_x", cur_x, 1);

    send(8'h0D);
    for (int i = 0; i < COLS; i++) send(8'($urandom_range(32, 126)));
    check("row0_last_addr", wr_addr, 12'h04F);
    check("row0_cur_x", cur_x, 0);
    check("row0_cur_y", cur_y, 1);
    check("row0_scroll", scroll_y, 0);

    for (int i = 0; i < 28; i++) send(8'h0A);
    check("lf_cur_y", cur_y, 29);
    send(8'h0A);
    check("scroll_y_1", scroll_y, 1);
    check("scroll_busy", busy, 1);
    n = 0; drops = 0; bad = 0;
    for (int i = 0; i < 84; i++) begin
      if (i == 10) begin rx_data = 8'h5A; rx_done_tick = 1'b1; end
      @(negedge clk);
      rx_done_tick = 1'b0;
      if (wr_en) begin
        n++;
        if (wr_addr > 12'h04F || wr_data != 7'h20) bad++;
      end
      if (drop_tick) drops++;
    end
    check("clear_writes", n, 80);
    check("clear_bad", bad, 0);
    check("clear_drops", drops, 1);
    check("clear_cur_y", cur_y, 29);
    check("clear_cur_x", cur_x, 0);
    check("clear_busy_done", busy, 0);

    send(8'h0D);
    send(8'h08);
    check("bs0_wr_en", wr_en, 0);
    check("bs0_cur_x", cur_x, 0);
    send(8'h68); send(8'h65); send(8'h6C); send(8'h6C); send(8'h6F);
    send(8'h08);
    check("bs5_cur_x", cur_x, 4);
    check("bs5_wr_en", wr_en, 1);
    check("bs5_addr", wr_addr, 12'h004);
    check("bs5_data", wr_data, 7'h20);

    for (int i = 0; i < 31; i++) begin
      send(8'h0A);
      wait_idle(200);
    end
    check("scroll_wrap", scroll_y, 2);

    send(8'h0D);
    for (int i = 0; i < COLS; i++) send(8'($urandom_range(32, 126)));
    wait_idle(200);
    check("eol_scroll", scroll_y, 3);
    check("eol_cur_x", cur_x, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        rx_data = rand_byte();
        rx_done_tick = 1'b1;
      end else begin
        rx_done_tick = 1'b0;
      end
      @(negedge clk);
    end
    rx_done_tick = 1'b0;
    wait_idle(200);

    send(8'h0A);
    repeat (20) @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    check("arst_wr_en", wr_en, 0);
    check("arst_addr", wr_addr, 0);
    check("arst_data", wr_data, 7'h20);
    check("arst_cur_x", cur_x, 0);
    check("arst_cur_y", cur_y, 0);
    check("arst_scroll", scroll_y, 0);
    check("arst_busy", busy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_init("reinit");

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
